// File: rtl/uart_rx_core_p_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core_p_if
// Brief    : Configuration, FIFO-control and status bundle of uart_rx_core_p.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_core_p_if #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             rx_in;
   logic [DIV_W-1:0] baud_div;
   logic [3:0]       data_bits;
   logic [1:0]       parity_mode;
   logic             stop_bits;
   logic             lsb_first;
   logic             rx_data_read;
   logic             error_clear;
   logic             fifo_clear;

   logic [8:0]       rx_data;
   logic             rx_data_valid;
   logic             frame_active;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_almost_full;
   logic [CNT_W-1:0] fifo_count;
   logic             framing_error;
   logic             parity_error;
   logic             break_detect;
   logic             overflow_error;
   logic             timeout_detect;
   logic             error_detected;

   modport master (
      output rx_in, baud_div, data_bits, parity_mode, stop_bits, lsb_first,
             rx_data_read, error_clear, fifo_clear,
      input  rx_data, rx_data_valid, frame_active, fifo_full, fifo_empty,
             fifo_almost_full, fifo_count, framing_error, parity_error,
             break_detect, overflow_error, timeout_detect, error_detected
   );

   modport slave (
      input  rx_in, baud_div, data_bits, parity_mode, stop_bits, lsb_first,
             rx_data_read, error_clear, fifo_clear,
      output rx_data, rx_data_valid, frame_active, fifo_full, fifo_empty,
             fifo_almost_full, fifo_count, framing_error, parity_error,
             break_detect, overflow_error, timeout_detect, error_detected
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core_p.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core_p
// Brief    : Oversampling UART receiver (3-sample majority vote) with runtime
//            frame format and FWFT receive FIFO; optional idle timeout when
//            UART_RX_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core_p #(
   parameter int FIFO_DEPTH   = 16,
   parameter int OVERSAMPLE   = 16,
   parameter int DIV_W        = 16,
   parameter int TIMEOUT_BITS = 40
) (
   input  wire             clk,
   input  wire             rst_n,
   uart_rx_core_p_if.slave bus
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int MID   = OVERSAMPLE / 2;
   localparam logic [OS_W-1:0] OS_S0   = OS_W'(MID - 1);
   localparam logic [OS_W-1:0] OS_S1   = OS_W'(MID);
   localparam logic [OS_W-1:0] OS_VOTE = OS_W'(MID + 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || TIMEOUT_BITS < 1) begin : g_param_check
      $error("uart_rx_core_p: illegal parameter set");
   end

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q;
   logic [DIV_W-1:0] div_q;
   logic [OS_W-1:0]  os_q;
   logic             s0_q, s1_q;
   logic [3:0]       nbits_q;
   logic [1:0]       pmode_q;
   logic             two_stop_q, lsb_q;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [8:0]       shreg_q, shreg_d;
   logic             par_q, par_d;
   logic             fe1_q, fe1_d;
   logic             wait_high_q, wait_high_d;
   logic             fe_q, pe_q, bk_q, ov_q;
   logic [8:0]       mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_q, rd_q;

   logic             rx_s, start_det, tick, vote, bit_end, maj;
   logic [3:0]       eff_bits;
   logic [8:0]       data_al;
   logic             data_x, par_bad, is_break;
   logic             push, set_fe, set_pe, set_bk;
   logic [CNT_W-1:0] count;
   logic             empty, full, pop, wr_en, drop;

   assign rx_s      = sync_q[1];
   assign start_det = (state_q == ST_IDLE) && !wait_high_q && !rx_s;
   assign tick      = (div_q == '0);
   assign vote      = tick && (os_q == OS_VOTE);
   assign bit_end   = tick && (os_q == OS_LAST);
   assign maj       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

   always_comb begin
      eff_bits = bus.data_bits;
      if (bus.data_bits < 4'd5)      eff_bits = 4'd5;
      else if (bus.data_bits > 4'd9) eff_bits = 4'd9;
   end

   // LSB-first words enter at bit 8, so they sit (9 - n) places too high.
   assign data_al  = lsb_q ? (shreg_q >> (4'd9 - nbits_q)) : shreg_q;
   assign data_x   = ^data_al;
   assign is_break = (data_al == 9'd0) && ((pmode_q == 2'd0) || !par_q);

   always_comb begin
      par_bad = 1'b0;
      case (pmode_q)
         2'd1:    par_bad = ~(data_x ^ par_q);
         2'd2:    par_bad = data_x ^ par_q;
         2'd3:    par_bad = ~par_q;
         default: par_bad = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 2'b11;
         div_q      <= '0;
         os_q       <= '0;
         s0_q       <= 1'b1;
         s1_q       <= 1'b1;
         nbits_q    <= 4'd8;
         pmode_q    <= 2'd0;
         two_stop_q <= 1'b0;
         lsb_q      <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], bus.rx_in};
         if (start_det) begin
            div_q      <= bus.baud_div;
            os_q       <= '0;
            nbits_q    <= eff_bits;
            pmode_q    <= bus.parity_mode;
            two_stop_q <= bus.stop_bits;
            lsb_q      <= bus.lsb_first;
         end else if (tick) begin
            div_q <= bus.baud_div;
            os_q  <= (os_q == OS_LAST) ? '0 : os_q + 1'b1;
         end else begin
            div_q <= div_q - 1'b1;
         end
         if (tick && os_q == OS_S0) s0_q <= rx_s;
         if (tick && os_q == OS_S1) s1_q <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         shreg_q     <= 9'd0;
         par_q       <= 1'b0;
         fe1_q       <= 1'b0;
         wait_high_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         par_q       <= par_d;
         fe1_q       <= fe1_d;
         wait_high_q <= wait_high_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      fe1_d       = fe1_q;
      wait_high_d = wait_high_q && !rx_s;
      push        = 1'b0;
      set_fe      = 1'b0;
      set_pe      = 1'b0;
      set_bk      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_det) begin
               state_d   = ST_START;
               bit_cnt_d = 4'd0;
               shreg_d   = 9'd0;
               par_d     = 1'b0;
               fe1_d     = 1'b0;
            end
         end
         ST_START: begin
            if (vote && maj)  state_d = ST_IDLE;
            else if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (vote) shreg_d = lsb_q ? {maj, shreg_q[8:1]} : {shreg_q[7:0], maj};
            if (bit_end) begin
               if (bit_cnt_q == nbits_q - 4'd1)
                  state_d = (pmode_q == 2'd0) ? ST_STOP1 : ST_PARITY;
               else
                  bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_PARITY: begin
            if (vote)    par_d   = maj;
            if (bit_end) state_d = ST_STOP1;
         end
         ST_STOP1: begin
            if (vote) begin
               if (is_break && !maj) begin
                  set_bk      = 1'b1;
                  wait_high_d = 1'b1;
                  state_d     = ST_IDLE;
               end else if (two_stop_q) begin
                  fe1_d = !maj;
               end else begin
                  push    = 1'b1;
                  set_fe  = !maj;
                  set_pe  = par_bad;
                  state_d = ST_IDLE;
               end
            end else if (bit_end && two_stop_q) begin
               state_d = ST_STOP2;
            end
         end
         ST_STOP2: begin
            if (vote) begin
               push    = 1'b1;
               set_fe  = fe1_q || !maj;
               set_pe  = par_bad;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A push against a full FIFO survives only if a pop frees a slot in the same cycle.
   assign count = wr_q - rd_q;
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign pop   = bus.rx_data_read && !empty;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (bus.fifo_clear) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop)   rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !bus.fifo_clear) mem_q[wr_q[AW-1:0]] <= data_al;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fe_q <= 1'b0;
         pe_q <= 1'b0;
         bk_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         fe_q <= set_fe | (fe_q & !bus.error_clear);
         pe_q <= set_pe | (pe_q & !bus.error_clear);
         bk_q <= set_bk | (bk_q & !bus.error_clear);
         ov_q <= (drop && !bus.fifo_clear) | (ov_q & !bus.error_clear);
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int TB_W = $clog2(TIMEOUT_BITS + 1);
   logic [OS_W-1:0] to_tick_q;
   logic [TB_W-1:0] to_bits_q;
   logic            to_q;
   logic            to_rst, to_run, to_hit;

   assign to_rst = start_det || bus.rx_data_read || bus.fifo_clear || empty;
   assign to_run = !to_rst && (state_q == ST_IDLE) && tick &&
                   (to_bits_q != TB_W'(TIMEOUT_BITS));
   assign to_hit = to_run && (to_tick_q == OS_LAST) &&
                   (to_bits_q == TB_W'(TIMEOUT_BITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_tick_q <= '0;
         to_bits_q <= '0;
         to_q      <= 1'b0;
      end else begin
         if (to_rst) begin
            to_tick_q <= '0;
            to_bits_q <= '0;
         end else if (to_run) begin
            if (to_tick_q == OS_LAST) begin
               to_tick_q <= '0;
               to_bits_q <= to_bits_q + 1'b1;
            end else begin
               to_tick_q <= to_tick_q + 1'b1;
            end
         end
         to_q <= to_hit | (to_q & !(bus.error_clear || (pop && count == CNT_W'(1))));
      end
   end

   assign bus.timeout_detect = to_q;
`else
   assign bus.timeout_detect = 1'b0;
`endif

   assign bus.rx_data          = empty ? 9'd0 : mem_q[rd_q[AW-1:0]];
   assign bus.rx_data_valid    = !empty;
   assign bus.frame_active     = (state_q != ST_IDLE);
   assign bus.fifo_full        = full;
   assign bus.fifo_empty       = empty;
   assign bus.fifo_almost_full = (count >= CNT_W'(FIFO_DEPTH - 2));
   assign bus.fifo_count       = count;
   assign bus.framing_error    = fe_q;
   assign bus.parity_error     = pe_q;
   assign bus.break_detect     = bk_q;
   assign bus.overflow_error   = ov_q;
   assign bus.error_detected   = fe_q | pe_q | bk_q | ov_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core_p
// Brief    : Directed self-checking bench for uart_rx_core_p (baud_div = 0,
//            16 clocks per bit); timeout scenario active with UART_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_core_p;
   localparam int FIFO_DEPTH   = 16;
   localparam int OVERSAMPLE   = 16;
   localparam int DIV_W        = 16;
   localparam int TIMEOUT_BITS = 40;
   localparam int BIT_CLKS     = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [1:0] cur_pm;
   logic       cur_two, cur_lsb;

   uart_rx_core_p_if #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) bus ();

   uart_rx_core_p #(
      .FIFO_DEPTH(FIFO_DEPTH), .OVERSAMPLE(OVERSAMPLE),
      .DIV_W(DIV_W), .TIMEOUT_BITS(TIMEOUT_BITS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

   task automatic set_cfg(input logic [3:0] b, input logic [1:0] pm, input logic two, input logic lsb);
      bus.data_bits = b; bus.parity_mode = pm; bus.stop_bits = two; bus.lsb_first = lsb;
      cur_pm = pm; cur_two = two; cur_lsb = lsb;
   endtask

   task automatic drive_bit(input logic v);
      bus.rx_in = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   // Called on a negedge; start bit is driven immediately.
   task automatic send_word(input logic [8:0] d, input int n, input logic flip_par, input logic bad_stop);
      logic x, p;
      x = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < n; i++) begin
         x ^= d[i];
         drive_bit(cur_lsb ? d[i] : d[n-1-i]);
      end
      p = (cur_pm == 2'd1) ? ~x : (cur_pm == 2'd2) ? x : 1'b1;
      if (cur_pm != 2'd0) drive_bit(p ^ flip_par);
      drive_bit(!bad_stop);
      if (cur_two) drive_bit(1'b1);
      bus.rx_in = 1'b1;
   endtask

   task automatic pop();
      bus.rx_data_read = 1'b1; @(negedge clk); bus.rx_data_read = 1'b0;
   endtask

   task automatic clr_err();
      bus.error_clear = 1'b1; @(negedge clk); bus.error_clear = 1'b0;
   endtask

   function automatic logic [8:0] wexp(input int i);
      return 9'((i * 37 + 11) & 8'hFF);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.rx_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.rx_data_valid); end
      n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", bus.fifo_empty); end
      n_cmp++; if (bus.fifo_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.fifo_count); end
      n_cmp++; if (bus.rx_data !== 9'd0) begin n_err++; $display("FAIL rst_data: got %h want 000", bus.rx_data); end
      n_cmp++; if ({bus.frame_active, bus.fifo_full, bus.fifo_almost_full, bus.error_detected, bus.timeout_detect} !== 5'b0) begin
         n_err++; $display("FAIL rst_misc: got %b want 00000", {bus.frame_active, bus.fifo_full, bus.fifo_almost_full, bus.error_detected, bus.timeout_detect}); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (bus.fifo_empty !== 1'b1 || bus.frame_active !== 1'b0) begin n_err++; $display("FAIL rst_release: got empty=%b active=%b want 1/0", bus.fifo_empty, bus.frame_active); end
   endtask

   task automatic test_basic();
      set_cfg(4'd8, 2'd0, 1'b0, 1'b1);
      send_word(9'h0A5, 8, 1'b0, 1'b0);
      n_cmp++; if (bus.rx_data !== 9'h0A5) begin n_err++; $display("FAIL basic_data: got %h want 0a5", bus.rx_data); end
      n_cmp++; if (bus.rx_data_valid !== 1'b1 || bus.fifo_count !== 5'd1) begin n_err++; $display("FAIL basic_valid: got %b/%0d want 1/1", bus.rx_data_valid, bus.fifo_count); end
      n_cmp++; if (bus.error_detected !== 1'b0) begin n_err++; $display("FAIL basic_flags: got %b want 0", bus.error_detected); end
      pop();
      n_cmp++; if (bus.rx_data_valid !== 1'b0 || bus.rx_data !== 9'd0) begin n_err++; $display("FAIL basic_pop: got %b/%h want 0/000", bus.rx_data_valid, bus.rx_data); end
      // 3 acts as 5 bits; a mid-frame change to 8 bits must be ignored
      set_cfg(4'd3, 2'd1, 1'b0, 1'b0);
      fork
         send_word(9'h013, 5, 1'b0, 1'b0);
         begin repeat (40) @(negedge clk); bus.data_bits = 4'd8; end
      join
      n_cmp++; if (bus.rx_data !== 9'h013) begin n_err++; $display("FAIL msb5_data: got %h want 013", bus.rx_data); end
      n_cmp++; if (bus.parity_error !== 1'b0) begin n_err++; $display("FAIL msb5_parity: got %b want 0", bus.parity_error); end
      pop();
   endtask

   task automatic test_parity();
      set_cfg(4'd9, 2'd2, 1'b1, 1'b0);
      send_word(9'h1C3, 9, 1'b0, 1'b0);
      n_cmp++; if (bus.rx_data !== 9'h1C3 || bus.parity_error !== 1'b0) begin n_err++; $display("FAIL 9e2_good: got %h pe=%b want 1c3 pe=0", bus.rx_data, bus.parity_error); end
      pop();
      send_word(9'h1C3, 9, 1'b1, 1'b0);
      n_cmp++; if (bus.rx_data !== 9'h1C3 || bus.fifo_count !== 5'd1) begin n_err++; $display("FAIL 9e2_bad_push: got %h cnt=%0d want 1c3 cnt=1", bus.rx_data, bus.fifo_count); end
      n_cmp++; if (bus.parity_error !== 1'b1 || bus.error_detected !== 1'b1 || bus.framing_error !== 1'b0) begin
         n_err++; $display("FAIL 9e2_bad_flag: got pe=%b ed=%b fe=%b want 1/1/0", bus.parity_error, bus.error_detected, bus.framing_error); end
      clr_err();
      n_cmp++; if (bus.parity_error !== 1'b0) begin n_err++; $display("FAIL 9e2_clear: got %b want 0", bus.parity_error); end
      pop();
   endtask

   task automatic test_framing_glitch();
      set_cfg(4'd8, 2'd0, 1'b0, 1'b1);
      send_word(9'h03C, 8, 1'b0, 1'b1);
      repeat (2 * BIT_CLKS) @(negedge clk);
      n_cmp++; if (bus.framing_error !== 1'b1 || bus.break_detect !== 1'b0) begin n_err++; $display("FAIL framing_flag: got fe=%b bk=%b want 1/0", bus.framing_error, bus.break_detect); end
      n_cmp++; if (bus.rx_data !== 9'h03C || bus.fifo_count !== 5'd1) begin n_err++; $display("FAIL framing_push: got %h cnt=%0d want 03c cnt=1", bus.rx_data, bus.fifo_count); end
      clr_err();
      pop();
      bus.rx_in = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.frame_active !== 1'b1) begin n_err++; $display("FAIL start_latency: got %b want 1", bus.frame_active); end
      bus.rx_in = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      n_cmp++; if (bus.frame_active !== 1'b0 || bus.fifo_count !== 5'd0 || bus.error_detected !== 1'b0) begin
         n_err++; $display("FAIL glitch: got act=%b cnt=%0d ed=%b want 0/0/0", bus.frame_active, bus.fifo_count, bus.error_detected); end
   endtask

   task automatic test_break();
      bus.rx_in = 1'b0;
      repeat (20 * BIT_CLKS) @(negedge clk);
      n_cmp++; if (bus.break_detect !== 1'b1 || bus.framing_error !== 1'b0) begin n_err++; $display("FAIL break_flag: got bk=%b fe=%b want 1/0", bus.break_detect, bus.framing_error); end
      n_cmp++; if (bus.fifo_count !== 5'd0 || bus.frame_active !== 1'b0) begin n_err++; $display("FAIL break_hold: got cnt=%0d act=%b want 0/0", bus.fifo_count, bus.frame_active); end
      bus.rx_in = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      send_word(9'h05A, 8, 1'b0, 1'b0);
      n_cmp++; if (bus.rx_data !== 9'h05A || bus.fifo_count !== 5'd1) begin n_err++; $display("FAIL break_rearm: got %h cnt=%0d want 05a cnt=1", bus.rx_data, bus.fifo_count); end
      clr_err();
      n_cmp++; if (bus.break_detect !== 1'b0) begin n_err++; $display("FAIL break_clear: got %b want 0", bus.break_detect); end
      pop();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         send_word(wexp(i), 8, 1'b0, 1'b0);
         n_cmp++; if (bus.fifo_count !== 5'(i + 1) || bus.fifo_almost_full !== (i + 1 >= FIFO_DEPTH - 2)) begin
            n_err++; $display("FAIL fill_%0d: got cnt=%0d af=%b want cnt=%0d af=%b", i, bus.fifo_count, bus.fifo_almost_full, i + 1, (i + 1 >= FIFO_DEPTH - 2)); end
      end
      n_cmp++; if (bus.fifo_full !== 1'b1 || bus.overflow_error !== 1'b0) begin n_err++; $display("FAIL full_no_ovf: got full=%b ovf=%b want 1/0", bus.fifo_full, bus.overflow_error); end
      send_word(9'h0F0, 8, 1'b0, 1'b0);
      n_cmp++; if (bus.overflow_error !== 1'b1 || bus.fifo_count !== 5'd16 || bus.error_detected !== 1'b1) begin
         n_err++; $display("FAIL overflow: got ovf=%b cnt=%0d ed=%b want 1/16/1", bus.overflow_error, bus.fifo_count, bus.error_detected); end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         n_cmp++; if (bus.rx_data !== wexp(i)) begin n_err++; $display("FAIL order_%0d: got %h want %h", i, bus.rx_data, wexp(i)); end
         pop();
      end
      n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL drained: got %b want 1", bus.fifo_empty); end
      clr_err();
   endtask

   task automatic test_full_read();
      for (int i = 0; i < FIFO_DEPTH; i++) send_word(wexp(i), 8, 1'b0, 1'b0);
      // read pulse lands on the cycle of the stop-bit vote (push edge)
      fork
         send_word(9'h0EE, 8, 1'b0, 1'b0);
         begin repeat (156) @(negedge clk); bus.rx_data_read = 1'b1; @(negedge clk); bus.rx_data_read = 1'b0; end
      join
      n_cmp++; if (bus.overflow_error !== 1'b0 || bus.fifo_count !== 5'd16) begin n_err++; $display("FAIL push_pop_full: got ovf=%b cnt=%0d want 0/16", bus.overflow_error, bus.fifo_count); end
      n_cmp++; if (bus.rx_data !== wexp(1)) begin n_err++; $display("FAIL push_pop_head: got %h want %h", bus.rx_data, wexp(1)); end
      repeat (FIFO_DEPTH - 1) pop();
      n_cmp++; if (bus.rx_data !== 9'h0EE || bus.fifo_count !== 5'd1) begin n_err++; $display("FAIL push_pop_tail: got %h cnt=%0d want 0ee cnt=1", bus.rx_data, bus.fifo_count); end
      pop();
   endtask

   task automatic test_fifo_clear();
      pop();
      n_cmp++; if (bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1) begin n_err++; $display("FAIL read_empty: got cnt=%0d empty=%b want 0/1", bus.fifo_count, bus.fifo_empty); end
      send_word(9'h011, 8, 1'b0, 1'b0);
      send_word(9'h022, 8, 1'b0, 1'b0);
      n_cmp++; if (bus.fifo_count !== 5'd2) begin n_err++; $display("FAIL clr_pre: got %0d want 2", bus.fifo_count); end
      bus.fifo_clear = 1'b1; @(negedge clk); bus.fifo_clear = 1'b0;
      n_cmp++; if (bus.fifo_count !== 5'd0 || bus.rx_data !== 9'd0 || bus.overflow_error !== 1'b0) begin
         n_err++; $display("FAIL clr_post: got cnt=%0d data=%h ovf=%b want 0/000/0", bus.fifo_count, bus.rx_data, bus.overflow_error); end
      send_word(9'h033, 8, 1'b0, 1'b0);
      n_cmp++; if (bus.rx_data !== 9'h033) begin n_err++; $display("FAIL clr_resume: got %h want 033", bus.rx_data); end
   endtask

   task automatic test_reset_midframe();
      bus.rx_in = 1'b0;
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.fifo_count !== 5'd0 || bus.frame_active !== 1'b0 || bus.fifo_empty !== 1'b1) begin
         n_err++; $display("FAIL rst_mid: got cnt=%0d act=%b empty=%b want 0/0/1", bus.fifo_count, bus.frame_active, bus.fifo_empty); end
      bus.rx_in = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
   endtask

   task automatic test_timeout();
      send_word(9'h042, 8, 1'b0, 1'b0);
      repeat (600) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
      n_cmp++; if (bus.timeout_detect !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b want 0", bus.timeout_detect); end
      repeat (60) @(negedge clk);
      n_cmp++; if (bus.timeout_detect !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b want 1", bus.timeout_detect); end
      pop();
      n_cmp++; if (bus.timeout_detect !== 1'b0) begin n_err++; $display("FAIL timeout_pop: got %b want 0", bus.timeout_detect); end
`else
      repeat (100) @(negedge clk);
      n_cmp++; if (bus.timeout_detect !== 1'b0) begin n_err++; $display("FAIL timeout_off: got %b want 0", bus.timeout_detect); end
      pop();
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rx_in = 1'b1; bus.baud_div = '0; bus.rx_data_read = 1'b0;
      bus.error_clear = 1'b0; bus.fifo_clear = 1'b0;
      set_cfg(4'd8, 2'd0, 1'b0, 1'b1);
      @(negedge clk);
      test_reset();
      test_basic();
      test_parity();
      test_framing_glitch();
      test_break();
      test_overflow();
      test_full_read();
      test_fifo_clear();
      test_reset_midframe();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_rx_core_p.md
# uart_rx_core_p

Parametrised UART receive core: the next-generation receiver behind `uart_rx_if`. It oversamples `rx_in` with a programmable tick divider and majority-votes each bit. Frame format is runtime-configurable (5–9 data bits, parity mode, 1/2 stop bits, bit order). Received words go into a parameterised first-word-fall-through FIFO with sticky error reporting. It sits between the pad synchroniser boundary and the register/bus layer.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; power of 2, ≥4.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥8.
- `DIV_W`, 16: width of `baud_div`.
- `TIMEOUT_BITS`, 40: idle bit periods before timeout.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_in` in 1: serial input, async, idle high.
- `baud_div` in DIV_W: clocks per oversample tick minus 1.
- `data_bits` in 4: data bits; <5 acts as 5, >9 acts as 9.
- `parity_mode` in 2: 0 none, 1 odd, 2 even, 3 mark.
- `stop_bits` in 1: 0 = one stop bit, 1 = two.
- `lsb_first` in 1: 1 = LSB transmitted first.
- `rx_data_read` in 1: pop FIFO head.
- `error_clear` in 1: clear sticky flags.
- `fifo_clear` in 1: flush FIFO.
- `rx_data` out 9: FIFO head, right-aligned, upper bits zero; 0 when empty.
- `rx_data_valid` out 1: equals `!fifo_empty`.
- `frame_active` out 1: FSM not IDLE.
- `fifo_full`, `fifo_empty`, `fifo_almost_full` out 1 each: almost-full means count ≥ FIFO_DEPTH−2.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `framing_error`, `parity_error`, `break_detect`, `overflow_error`, `timeout_detect` out 1 each: sticky flags.
- `error_detected` out 1: OR of framing, parity, break and overflow.

## Operation
- **Input path:** 2-flop synchroniser on `rx_in`, reset to 1. The tick counter reloads `baud_div`, giving one tick per `baud_div`+1 clocks; it free-runs and restarts on start detection.
- **FSM states:** IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE → START:** on synchronised `rx_in`==0. The frame config is latched here; config changes mid-frame are ignored.
- **Sampling:** each bit is sampled at ticks M−1, M, M+1 (M = OVERSAMPLE/2); the bit value is the majority of the 3 samples.
- **START:** majority 1 is treated as a glitch and returns to IDLE with no flags. Majority 0 moves to DATA at the end of the bit.
- **DATA:** collects the effective data bit count. LSB-first shifts in from the top; MSB-first shifts in from the bottom. The result is right-aligned.
- **PARITY:** skipped when mode is 0. Odd requires XOR(data, p)=1; even requires XOR(data, p)=0; mark requires p=1. A mismatch sets `parity_error`.
- **Stop bits:** STOP1, then STOP2 if `stop_bits`. A majority-0 stop bit sets `framing_error`.
- **End of frame:** the FSM returns to IDLE at the mid-point vote of the last stop bit, not at bit end, so it can resync early.
- **Break:** data all 0, parity bit 0 if present, and STOP1 = 0 sets `break_detect`, sets no framing error, and pushes nothing. The FSM then waits in IDLE for `rx_in`==1 before re-arming.
- **Push:** words with parity or framing errors are still pushed.
- **FIFO:** first-word fall-through.
  - `rx_data_read` with valid pops; read while empty is ignored.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push while full without pop: the word is dropped and `overflow_error` is set.
  - `fifo_clear` has priority over a same-cycle push and pop; the word is discarded. Reception continues.
- **Sticky flags:** a set condition in the same cycle as `error_clear` wins (flag stays set).

## Timing
- **Reset:** all outputs 0, except `fifo_empty`=1; the FSM is in IDLE. Reset mid-frame aborts the frame and flushes the FIFO.
- **Start latency:** a falling edge on `rx_in` enters START within 2 clocks (synchroniser) plus 1 clock.
- **Push latency:** the push takes effect on the clock edge after the last stop mid-point vote. `rx_data_valid`, `fifo_count` and `rx_data` update on that edge.
- **Read:** on the edge where `rx_data_read` && valid, the count decrements and the next head appears combinationally from the FIFO RAM/regs.
- **Flags:** set on the same edge as the push (or the drop/break decision).

## Configuration
- **`UART_RX_TIMEOUT_EN` defined:**
  - An idle counter counts bit periods (OVERSAMPLE ticks) while the FSM is IDLE and the FIFO is not empty.
  - It resets on a start bit, on `rx_data_read` and on `fifo_clear`.
  - Reaching TIMEOUT_BITS sets `timeout_detect`.
  - `timeout_detect` is cleared by `error_clear` or by a pop that empties the FIFO.
- **Undefined:** there is no counter, and `timeout_detect` is tied to 0.

## Test plan
- **Basic frame:** `baud_div`=0, 8N1, LSB-first, send 0xA5 → `rx_data`=0x0A5 and `rx_data_valid`=1 by 10×16 clocks after the start edge; no flags set.
- **9-bit even parity, two stop bits:** 9E2, MSB-first, send 0x1C3 with correct parity → 0x1C3. Resend with a flipped parity bit → word pushed and `parity_error`=1, cleared by `error_clear`.
- **Framing and glitch:** 8N1 with stop bit forced 0 → `framing_error`=1. A 3-clock low glitch on idle line → FSM returns to IDLE and nothing is pushed.
- **Break:** `rx_in` held low for 2 frame times → `break_detect`=1, `fifo_count` unchanged, no re-arm until the line goes high.
- **Overflow and full edge cases:**
  - Send FIFO_DEPTH+1 frames without reads → `fifo_full`=1, `overflow_error`=1, and the first 16 words read back in order.
  - Push coinciding with a read while full → no overflow.
- **Timeout (UART_RX_TIMEOUT_EN):** one word, then idle for 40 bit times → `timeout_detect`=1. A read that empties the FIFO → 0.
